// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, addr+R/W, ACK, one data byte, ACK/NACK, STOP.
// Ports: ref_clk/rst_n (sync active-low); cmd_valid/cmd_ready/cmd_rw/cmd_addr/cmd_wdata
// command side; rd_data/done/ack_err/busy status; scl_oe/sda_oe open-drain pulls; sda_in pad.
module i2c_master_ctrl #(
    parameter int DELAY = 5000
) (
    input  logic       ref_clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic [7:0] rd_data,
    output logic       done,
    output logic       ack_err,
    output logic       busy,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_in
);
    localparam int QUARTER = DELAY / 4;
    localparam int QW = (QUARTER > 1) ? $clog2(QUARTER) : 1;
    localparam logic [QW-1:0] QLAST = QW'(QUARTER - 1);

    typedef enum logic [2:0] {
        IDLE, START, ADDR, AACK, DATA, DACK, STOP
    } state_t;

    state_t        state, state_n;
    logic [QW-1:0] qcnt, qcnt_n;
    logic [1:0]    phase, phase_n;
    logic [2:0]    bitn, bitn_n;
    logic [7:0]    shreg, shreg_n;
    logic [7:0]    wdata, wdata_n;
    logic [7:0]    rd_data_n;
    logic          rw, rw_n;
    logic          samp, samp_n;
    logic          done_n, ack_err_n;
    logic          scl_n, sda_n;
    logic          sync1, sync2;
    logic          q_end, bit_end, sample;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign q_end     = (qcnt == QLAST);
    assign bit_end   = q_end && (phase == 2'd3);
    assign sample    = busy && q_end && (phase == 2'd2);

    always_comb begin
        state_n   = state;
        qcnt_n    = qcnt;
        phase_n   = phase;
        bitn_n    = bitn;
        shreg_n   = shreg;
        wdata_n   = wdata;
        rw_n      = rw;
        samp_n    = samp;
        rd_data_n = rd_data;
        done_n    = 1'b0;
        ack_err_n = ack_err;
        scl_n     = 1'b0;
        sda_n     = 1'b0;

        if (state != IDLE) begin
            qcnt_n = q_end ? '0 : qcnt + 1'b1;
            if (q_end) phase_n = phase + 1'b1;
        end

        // Read bits shift in at the sample point; write bits shift out at bit end.
        if (sample) begin
            samp_n = sync2;
            if (state == DATA && rw) shreg_n = {shreg[6:0], sync2};
        end

        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_n   = START;
                    qcnt_n    = '0;
                    phase_n   = 2'd0;
                    bitn_n    = 3'd0;
                    rw_n      = cmd_rw;
                    wdata_n   = cmd_wdata;
                    shreg_n   = {cmd_addr, cmd_rw};
                    ack_err_n = 1'b0;
                end
            end
            START: if (bit_end) state_n = ADDR;
            ADDR: begin
                if (bit_end) begin
                    shreg_n = {shreg[6:0], 1'b0};
                    bitn_n  = bitn + 1'b1;
                    if (bitn == 3'd7) state_n = AACK;
                end
            end
            AACK: begin
                if (bit_end) begin
                    if (samp) begin
                        ack_err_n = 1'b1;
                        state_n   = STOP;
                    end else begin
                        shreg_n = wdata;
                        state_n = DATA;
                    end
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (!rw) shreg_n = {shreg[6:0], 1'b0};
                    bitn_n = bitn + 1'b1;
                    if (bitn == 3'd7) state_n = DACK;
                end
            end
            DACK: begin
                if (bit_end) begin
                    if (!rw && samp) ack_err_n = 1'b1;
                    state_n = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    if (rw && !ack_err) rd_data_n = shreg;
                end
            end
            default: state_n = IDLE;
        endcase

        // Pad drive is decoded from next-state values so the registered
        // pins line up exactly with the phase boundaries.
        case (state_n)
            START: begin
                sda_n = phase_n[1];
                scl_n = (phase_n == 2'd3);
            end
            ADDR: begin
                scl_n = (phase_n == 2'd0) || (phase_n == 2'd3);
                sda_n = ~shreg_n[7];
            end
            DATA: begin
                scl_n = (phase_n == 2'd0) || (phase_n == 2'd3);
                sda_n = ~rw_n & ~shreg_n[7];
            end
            AACK, DACK: begin
                scl_n = (phase_n == 2'd0) || (phase_n == 2'd3);
            end
            STOP: begin
                scl_n = (phase_n == 2'd0);
                sda_n = ~phase_n[1];
            end
            default: begin
                scl_n = 1'b0;
                sda_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ref_clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            qcnt    <= '0;
            phase   <= 2'd0;
            bitn    <= 3'd0;
            shreg   <= 8'd0;
            wdata   <= 8'd0;
            rw      <= 1'b0;
            samp    <= 1'b0;
            rd_data <= 8'd0;
            done    <= 1'b0;
            ack_err <= 1'b0;
            scl_oe  <= 1'b0;
            sda_oe  <= 1'b0;
            sync1   <= 1'b1;
            sync2   <= 1'b1;
        end else begin
            state   <= state_n;
            qcnt    <= qcnt_n;
            phase   <= phase_n;
            bitn    <= bitn_n;
            shreg   <= shreg_n;
            wdata   <= wdata_n;
            rw      <= rw_n;
            samp    <= samp_n;
            rd_data <= rd_data_n;
            done    <= done_n;
            ack_err <= ack_err_n;
            scl_oe  <= scl_n;
            sda_oe  <= sda_n;
            sync1   <= sda_in;
            sync2   <= sync1;
        end
    end
endmodule
